// File: rtl/useq_pkg.sv
// Shared microsequencer definitions: COND field encodings and LC-3 defaults.
package useq_pkg;

  typedef enum logic [2:0] {
    COND_NONE = 3'd0,
    COND_RDY  = 3'd1,
    COND_BEN  = 3'd2,
    COND_ADDR = 3'd3,
    COND_PRIV = 3'd4,
    COND_INT  = 3'd5
  } cond_e;

  // Entry i (8 bits each) is the uaddr bit that qual[i] ORs into.
  localparam logic [39:0] LC3_QBIT_MAP = 40'h0403000201;
  localparam int unsigned LC3_RESET_UADDR = 18;

endpackage

// File: rtl/useq_ustack.sv
// Micro-subroutine return stack: plain LIFO that refuses push-when-full and pop-when-empty.
module ustack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 top,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [DW-1:0] ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full    = (ptr == DW'(DEPTH));
    empty   = (ptr == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_idx  = AW'(ptr);
    rd_idx  = AW'(ptr - DW'(1));
    top     = mem[rd_idx];
    depth   = ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (do_push) begin
      ptr <= ptr + DW'(1);
    end else if (do_pop) begin
      ptr <= ptr - DW'(1);
    end
  end

  // Storage is not reset; entries at or above ptr are never read as valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/useq.sv
// Microsequencer: holds the micro-PC and selects the next micro-address from dispatch, call/ret and qualified branches.
module useq
  import useq_pkg::*;
#(
  parameter int unsigned           UADDR_W     = 6,
  parameter int unsigned           NQUAL       = 5,
  parameter int unsigned           COND_W      = 3,
  parameter int unsigned           OP_W        = 4,
  parameter int unsigned           STACK_D     = 4,
  parameter int unsigned           RESET_UADDR = LC3_RESET_UADDR,
  parameter logic [8*NQUAL-1:0]    QBIT_MAP    = LC3_QBIT_MAP
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          ird,
  input  logic [COND_W-1:0]             cond,
  input  logic [UADDR_W-1:0]            j,
  input  logic                          call,
  input  logic                          ret,
  input  logic [NQUAL-1:0]              qual,
  input  logic [OP_W-1:0]               opcode,
  output logic [UADDR_W-1:0]            uaddr,
  output logic [$clog2(STACK_D+1)-1:0]  depth,
  output logic                          ovf,
  output logic                          unf,
  output logic                          err
);

  logic [UADDR_W-1:0] tgt;
  logic [UADDR_W-1:0] ret_addr;
  logic [UADDR_W-1:0] top;
  logic               full;
  logic               empty;
  logic               active;
  logic               push;
  logic               pop;

  // Only the qualifier selected by cond may OR into its mapped bit of j.
  always_comb begin
    tgt = j;
    for (int unsigned i = 0; i < NQUAL; i++) begin
      if (cond == COND_W'(i + 1)) begin
        for (int unsigned b = 0; b < UADDR_W; b++) begin
          if (QBIT_MAP[8*i +: 8] == 8'(b)) begin
            tgt[b] = j[b] | qual[i];
          end
        end
      end
    end
  end

  always_comb begin
    ret_addr = uaddr + UADDR_W'(1);
    active   = !rst && !stall && !ird;
    push     = active && call;
    pop      = active && !call && ret;
  end

  ustack #(
    .DEPTH (STACK_D),
    .W     (UADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr),
    .top   (top),
    .full  (full),
    .empty (empty),
    .depth (depth)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      uaddr <= UADDR_W'(RESET_UADDR);
      ovf   <= 1'b0;
      unf   <= 1'b0;
      err   <= 1'b0;
    end else if (!stall) begin
      if (ird) begin
        uaddr <= UADDR_W'(opcode);
      end else if (call) begin
        uaddr <= tgt;
        if (ret)  err <= 1'b1;
        if (full) ovf <= 1'b1;
      end else if (ret) begin
        if (empty) begin
          uaddr <= UADDR_W'(RESET_UADDR);
          unf   <= 1'b1;
        end else begin
          uaddr <= top;
        end
      end else begin
        uaddr <= tgt;
      end
    end
  end

endmodule

// File: tb/tb_useq.sv
// Scoreboard bench for useq: directed vectors push expected state, a monitor pops and compares after each edge.
module tb_useq;

  logic       clk = 1'b0;
  logic       rst, stall, ird, call, ret;
  logic [2:0] cond;
  logic [5:0] j;
  logic [4:0] qual;
  logic [3:0] opcode;
  logic [5:0] uaddr;
  logic [2:0] depth;
  logic       ovf, unf, err;

  typedef struct {
    string      name;
    logic [5:0] uaddr;
    logic [2:0] depth;
    logic       ovf;
    logic       unf;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  useq #(
    .UADDR_W     (6),
    .NQUAL       (5),
    .COND_W      (3),
    .OP_W        (4),
    .STACK_D     (4),
    .RESET_UADDR (18),
    .QBIT_MAP    (40'h0403000201)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .ird    (ird),
    .cond   (cond),
    .j      (j),
    .call   (call),
    .ret    (ret),
    .qual   (qual),
    .opcode (opcode),
    .uaddr  (uaddr),
    .depth  (depth),
    .ovf    (ovf),
    .unf    (unf),
    .err    (err)
  );

  // Monitor: every edge that follows a driven vector yields one output state.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (uaddr !== e.uaddr || depth !== e.depth || ovf !== e.ovf ||
          unf !== e.unf || err !== e.err) begin
        failures++;
        $display("FAIL %s: got uaddr=%0d depth=%0d ovf=%0b unf=%0b err=%0b, want uaddr=%0d depth=%0d ovf=%0b unf=%0b err=%0b",
                 e.name, uaddr, depth, ovf, unf, err, e.uaddr, e.depth, e.ovf, e.unf, e.err);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic s, input logic id,
                      input logic [2:0] c, input logic [5:0] jj, input logic cl,
                      input logic rt, input logic [4:0] q, input logic [3:0] op,
                      input logic [5:0] eu, input logic [2:0] ed,
                      input logic eo, input logic eun, input logic ee);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; ird = id; cond = c; j = jj;
    call = cl; ret = rt; qual = q; opcode = op;
    e.name = nm; e.uaddr = eu; e.depth = ed; e.ovf = eo; e.unf = eun; e.err = ee;
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b1; ird = 1'b0; cond = '0; j = '0;
    call = 1'b0; ret = 1'b0; qual = '0; opcode = '0;

    //    name            rst stl ird cond j   cl rt qual      op     uaddr dp ov un er
    step("reset",         1, 1, 0, 3'd0, 6'd0,  0, 0, 5'b00000, 4'h0, 6'd18, 3'd0, 0, 0, 0);
    step("dispatch",      0, 0, 1, 3'd0, 6'd40, 1, 0, 5'b00000, 4'hB, 6'd11, 3'd0, 0, 0, 0);
    step("br_rdy_lo",     0, 0, 0, 3'd1, 6'd33, 0, 0, 5'b00000, 4'h0, 6'd33, 3'd0, 0, 0, 0);
    step("br_rdy_hi",     0, 0, 0, 3'd1, 6'd33, 0, 0, 5'b00001, 4'h0, 6'd35, 3'd0, 0, 0, 0);
    step("br_int",        0, 0, 0, 3'd5, 6'd32, 0, 0, 5'b10000, 4'h0, 6'd48, 3'd0, 0, 0, 0);
    step("br_int_other",  0, 0, 0, 3'd5, 6'd32, 0, 0, 5'b01111, 4'h0, 6'd32, 3'd0, 0, 0, 0);
    step("br_none",       0, 0, 0, 3'd0, 6'd32, 0, 0, 5'b11111, 4'h0, 6'd32, 3'd0, 0, 0, 0);
    step("br_cond7",      0, 0, 0, 3'd7, 6'd32, 0, 0, 5'b11111, 4'h0, 6'd32, 3'd0, 0, 0, 0);
    step("br_ben",        0, 0, 0, 3'd2, 6'd0,  0, 0, 5'b00010, 4'h0, 6'd4,  3'd0, 0, 0, 0);
    step("br_addr",       0, 0, 0, 3'd3, 6'd0,  0, 0, 5'b00100, 4'h0, 6'd1,  3'd0, 0, 0, 0);
    step("br_priv",       0, 0, 0, 3'd4, 6'd0,  0, 0, 5'b01000, 4'h0, 6'd8,  3'd0, 0, 0, 0);

    step("goto20",        0, 0, 0, 3'd0, 6'd20, 0, 0, 5'b00000, 4'h0, 6'd20, 3'd0, 0, 0, 0);
    step("call40",        0, 0, 0, 3'd0, 6'd40, 1, 0, 5'b00000, 4'h0, 6'd40, 3'd1, 0, 0, 0);
    step("ret21",         0, 0, 0, 3'd0, 6'd0,  0, 1, 5'b00000, 4'h0, 6'd21, 3'd0, 0, 0, 0);
    step("goto63",        0, 0, 0, 3'd0, 6'd63, 0, 0, 5'b00000, 4'h0, 6'd63, 3'd0, 0, 0, 0);
    step("call_wrap",     0, 0, 0, 3'd0, 6'd5,  1, 0, 5'b00000, 4'h0, 6'd5,  3'd1, 0, 0, 0);
    step("ret_wrap",      0, 0, 0, 3'd0, 6'd0,  0, 1, 5'b00000, 4'h0, 6'd0,  3'd0, 0, 0, 0);

    step("goto1",         0, 0, 0, 3'd0, 6'd1,  0, 0, 5'b00000, 4'h0, 6'd1,  3'd0, 0, 0, 0);
    step("call_a",        0, 0, 0, 3'd0, 6'd2,  1, 0, 5'b00000, 4'h0, 6'd2,  3'd1, 0, 0, 0);
    step("call_b",        0, 0, 0, 3'd0, 6'd3,  1, 0, 5'b00000, 4'h0, 6'd3,  3'd2, 0, 0, 0);
    step("call_c",        0, 0, 0, 3'd0, 6'd4,  1, 0, 5'b00000, 4'h0, 6'd4,  3'd3, 0, 0, 0);
    step("call_d",        0, 0, 0, 3'd0, 6'd5,  1, 0, 5'b00000, 4'h0, 6'd5,  3'd4, 0, 0, 0);
    step("call_ovf",      0, 0, 0, 3'd0, 6'd6,  1, 0, 5'b00000, 4'h0, 6'd6,  3'd4, 1, 0, 0);
    step("ret_a",         0, 0, 0, 3'd0, 6'd0,  0, 1, 5'b00000, 4'h0, 6'd5,  3'd3, 1, 0, 0);
    step("ret_b",         0, 0, 0, 3'd0, 6'd0,  0, 1, 5'b00000, 4'h0, 6'd4,  3'd2, 1, 0, 0);
    step("ret_c",         0, 0, 0, 3'd0, 6'd0,  0, 1, 5'b00000, 4'h0, 6'd3,  3'd1, 1, 0, 0);
    step("ret_d",         0, 0, 0, 3'd0, 6'd0,  0, 1, 5'b00000, 4'h0, 6'd2,  3'd0, 1, 0, 0);
    step("ret_unf",       0, 0, 0, 3'd0, 6'd0,  0, 1, 5'b00000, 4'h0, 6'd18, 3'd0, 1, 1, 0);

    step("call10",        0, 0, 0, 3'd0, 6'd10, 1, 0, 5'b00000, 4'h0, 6'd10, 3'd1, 1, 1, 0);
    for (int i = 0; i < 3; i++)
      step("stall_hold",  0, 1, 1, 3'd1, 6'd50, 0, 1, 5'b11111, 4'h7, 6'd10, 3'd1, 1, 1, 0);
    step("call_ret_conf", 0, 0, 0, 3'd0, 6'd9,  1, 1, 5'b00000, 4'h0, 6'd9,  3'd2, 1, 1, 1);
    step("ret_conf",      0, 0, 0, 3'd0, 6'd0,  0, 1, 5'b00000, 4'h0, 6'd11, 3'd1, 1, 1, 1);
    step("ret_19",        0, 0, 0, 3'd0, 6'd0,  0, 1, 5'b00000, 4'h0, 6'd19, 3'd0, 1, 1, 1);

    step("call_pre_rst",  0, 0, 0, 3'd0, 6'd30, 1, 0, 5'b00000, 4'h0, 6'd30, 3'd1, 1, 1, 1);
    step("rst_in_sub",    1, 0, 0, 3'd0, 6'd0,  0, 0, 5'b00000, 4'h0, 6'd18, 3'd0, 0, 0, 0);
    step("ret_after_rst", 0, 0, 0, 3'd0, 6'd0,  0, 1, 5'b00000, 4'h0, 6'd18, 3'd0, 0, 1, 0);
    step("ird_ignores_rt",0, 0, 1, 3'd0, 6'd0,  0, 1, 5'b00000, 4'hF, 6'd15, 3'd0, 0, 1, 0);

    @(negedge clk);
    call = 1'b0; ret = 1'b0; ird = 1'b0; stall = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
